mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares a single 4:1 selection datapath among four requesters. Each requester presents a data word and holds a request. The arbiter picks one winner fairly, drives the 2-bit select, and captures the winner's word into an output register. It then hands the word downstream over a valid/ready handshake. It sits in front of the 4:1 mux and replaces static select inputs with a sequenced, fair grant.

## Interface
- WIDTH, 1, data width per requester and of the output word
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  4  req[i] high = requester i has a word pending; held until ack[i]
- din  input  4*WIDTH  packed words, requester i at din[i*WIDTH +: WIDTH]
- ack  output  4  one-hot, one-cycle pulse: requester i's word was captured
- sel  output  2  index of the last captured requester (mux select)
- out_valid  output  1  out_data holds an undelivered word
- out_data  output  WIDTH  captured word
- out_ready  input  1  downstream accepts out_data when out_valid & out_ready

## Operation
- Reset values: out_valid=0, out_data=0, ack=0000, sel=00, rotation pointer ptr=0, state IDLE.
- Effective request: eff = req & ~ack. The requester being acked this cycle is masked, so a stale req is never re-captured.
- Winner: the first i with eff[i]=1, scanning ptr, ptr+1, … mod 4.
- Capture condition: cap = |eff & (state==IDLE | out_ready).
- On cap at edge E:
  - out_data <= din[winner]
  - sel <= winner
  - out_valid <= 1
  - ack <= onehot(winner) for exactly one cycle
  - ptr <= winner+1 mod 4 (wraps 3 → 0)
  - state <= BUSY
- States:
  - IDLE (out_valid=0): go to BUSY on cap, else stay.
  - BUSY (out_valid=1): on out_ready & cap, reload in place (back-to-back) and stay BUSY. On out_ready & ~cap, out_valid <= 0 and go to IDLE. On ~out_ready, hold out_data, sel and ptr unchanged and capture nothing.
- ack is 0 whenever no capture happened at the preceding edge. At most one ack bit is ever high.
- Requester protocol: din[i] must be stable while req[i]=1. Dropping req before ack is illegal; the bench flags it but the RTL need not handle it.
- A requester that drops req in the ack cycle and re-raises it later is treated as a new request.
- Reset mid-operation: all registers return to reset values immediately. Any in-flight word is discarded, and its requester sees no ack.

## Timing
- Latency from req rising to ack high and out_valid high: 1 cycle, if the arbiter is IDLE or out_ready=1.
- Throughput: one word per cycle while out_ready=1 and at least one unmasked request exists.
- Fairness: with all four requesting continuously, captures occur in strict rotation. Each requester waits at most 3 other captures.
- Simultaneous events:
  - Delivery and a new capture in the same cycle produce no bubble.
  - A new req arriving in the ack cycle of another requester is eligible that same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package:
  - NREQ=4 and SELW=2 constants
  - state enum {IDLE, BUSY}
  - onehot function (2-bit index → 4-bit)
- Sub-module rr_pick4: purely combinational. Inputs eff[3:0] and ptr[1:0]; outputs found and idx[1:0]. The registered state, handshake and data capture stay in the top module.

## Test plan
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> all outputs zero immediately. After release with req=0, everything stays idle.
- Single requester: WIDTH=8, req=0100, din[2]=8'hA5, out_ready=1 -> next cycle ack=0100, sel=10, out_data=A5, out_valid=1. Drop req -> out_valid=0 one cycle later.
- Full contention: req=1111 held, a new word after each ack, out_ready=1, ptr=0 -> acks 0001,0010,0100,1000,0001 on consecutive cycles with no bubbles.
- Backpressure: out_ready=0 with out_valid=1 and req=0011 pending -> out_data, sel and ptr frozen, ack stays 0000. Raise out_ready -> the next capture occurs that cycle with the correct rotation.
- Stale-request mask: only requester 1 requests and drops req one cycle after ack -> exactly one capture, not two.
- Wrap-around: ptr=3 with req=1001 -> requester 3 wins, then requester 0, and ptr returns to 1.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the four-way round-robin arbiter.
package mux4_rr_arbiter_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/downstream bundle of the arbiter: request words in, acked word out over valid/ready.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 1
);
    import mux4_rr_arbiter_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       ack;
    logic [SELW-1:0]       sel;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;

    modport master (
        output req, din, out_ready,
        input  ack, sel, out_valid, out_data
    );

    modport slave (
        input  req, din, out_ready,
        output ack, sel, out_valid, out_data
    );

endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational rotating priority search: first set bit of eff starting at ptr, wrapping mod 4.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] eff,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] cand;

    // Scan farthest-first so the candidate closest to ptr is the last to be written.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + SELW'(k);
            if (eff[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter capturing one of four requester words into a valid/ready output register.
//   state | meaning
//   IDLE  | output register empty, out_valid=0
//   BUSY  | output register holds an undelivered word, out_valid=1
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [SELW-1:0] sel_q, sel_nxt;
    logic [NREQ-1:0] ack_q, ack_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic [WIDTH-1:0] win_data;

    logic [NREQ-1:0] eff;
    logic            found;
    logic [SELW-1:0] win_idx;
    logic            cap;

    // A requester in its ack cycle still shows req; mask it so its word is not taken twice.
    assign eff = bus.req & ~ack_q;
    assign cap = found & ((state == IDLE) | bus.out_ready);

    rr_pick4 u_pick (
        .eff   (eff),
        .ptr   (ptr),
        .found (found),
        .idx   (win_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == SELW'(i)) begin
                win_data = bus.din[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cap) state_nxt = BUSY;
            BUSY: if (bus.out_ready && !cap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack_nxt  = '0;
        sel_nxt  = sel_q;
        ptr_nxt  = ptr;
        data_nxt = data_q;
        if (cap) begin
            ack_nxt  = onehot(win_idx);
            sel_nxt  = win_idx;
            ptr_nxt  = win_idx + SELW'(1);
            data_nxt = win_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= '0;
            sel_q  <= '0;
            ptr    <= '0;
            data_q <= '0;
        end else begin
            ack_q  <= ack_nxt;
            sel_q  <= sel_nxt;
            ptr    <= ptr_nxt;
            data_q <= data_nxt;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = (state == BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: linear steps with hand-computed expectations.
module tb_mux4_rr_arbiter;
    import mux4_rr_arbiter_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux4_rr_arbiter_if #(.WIDTH(W)) bus ();

    mux4_rr_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ack, input logic [1:0] sel,
                              input logic valid, input logic [7:0] data);
        chk({tag, ".ack"},   32'(bus.ack),       32'(ack));
        chk({tag, ".sel"},   32'(bus.sel),       32'(sel));
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
        chk({tag, ".data"},  32'(bus.out_data),  32'(data));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int i, input logic [7:0] v);
        bus.din[i*W +: W] = v;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req       = 4'b0000;
        bus.din       = '0;
        bus.out_ready = 1'b1;

        step();
        step();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 8'h00);
        rst_n = 1'b1;
        step();
        expect_out("idle_after_reset", 4'b0000, 2'd0, 1'b0, 8'h00);

        // Single requester 2: ptr 0 -> 3
        bus.req = 4'b0100;
        set_din(2, 8'hA5);
        step();
        expect_out("single.cap", 4'b0100, 2'd2, 1'b1, 8'hA5);
        bus.req = 4'b0000;
        step();
        expect_out("single.drain", 4'b0000, 2'd2, 1'b0, 8'hA5);

        // Wrap-around from ptr 3: requester 3 then 0, ptr ends at 1
        bus.req = 4'b1001;
        set_din(3, 8'h30);
        set_din(0, 8'h0C);
        step();
        expect_out("wrap.r3", 4'b1000, 2'd3, 1'b1, 8'h30);
        bus.req = 4'b0001;
        step();
        expect_out("wrap.r0", 4'b0001, 2'd0, 1'b1, 8'h0C);
        bus.req = 4'b0000;
        step();
        expect_out("wrap.drain", 4'b0000, 2'd0, 1'b0, 8'h0C);

        // ptr=1 selects requester 1 over 0; requester 1 holds req in its ack cycle
        bus.req = 4'b0011;
        set_din(1, 8'h5A);
        set_din(0, 8'hC3);
        step();
        expect_out("ptr1.r1", 4'b0010, 2'd1, 1'b1, 8'h5A);
        step();
        expect_out("stale.r0", 4'b0001, 2'd0, 1'b1, 8'hC3);
        bus.req = 4'b0001;
        step();
        expect_out("stale.masked", 4'b0000, 2'd0, 1'b0, 8'hC3);
        bus.req = 4'b0000;
        step();
        expect_out("stale.idle", 4'b0000, 2'd0, 1'b0, 8'hC3);

        // Move ptr to 0 via requester 3
        bus.req = 4'b1000;
        set_din(3, 8'h77);
        step();
        expect_out("ptr0.r3", 4'b1000, 2'd3, 1'b1, 8'h77);
        bus.req = 4'b0000;
        step();
        expect_out("ptr0.drain", 4'b0000, 2'd3, 1'b0, 8'h77);

        // Full contention
        bus.req = 4'b1111;
        set_din(0, 8'h11);
        set_din(1, 8'h22);
        set_din(2, 8'h33);
        set_din(3, 8'h44);
        step();
        expect_out("rr.1", 4'b0001, 2'd0, 1'b1, 8'h11);
        set_din(0, 8'h55);
        step();
        expect_out("rr.2", 4'b0010, 2'd1, 1'b1, 8'h22);
        set_din(1, 8'h99);
        step();
        expect_out("rr.3", 4'b0100, 2'd2, 1'b1, 8'h33);
        bus.req = 4'b1011;
        step();
        expect_out("rr.4", 4'b1000, 2'd3, 1'b1, 8'h44);
        bus.req = 4'b0011;
        step();
        expect_out("rr.5", 4'b0001, 2'd0, 1'b1, 8'h55);
        set_din(0, 8'h66);

        // Backpressure: nothing moves while out_ready=0
        bus.out_ready = 1'b0;
        step();
        expect_out("bp.hold1", 4'b0000, 2'd0, 1'b1, 8'h55);
        step();
        expect_out("bp.hold2", 4'b0000, 2'd0, 1'b1, 8'h55);
        bus.out_ready = 1'b1;
        step();
        expect_out("bp.release", 4'b0010, 2'd1, 1'b1, 8'h99);
        bus.req = 4'b0001;
        step();
        expect_out("bp.next", 4'b0001, 2'd0, 1'b1, 8'h66);
        bus.req = 4'b0000;
        step();
        expect_out("bp.drain", 4'b0000, 2'd0, 1'b0, 8'h66);

        // Reset mid-operation with a word in flight
        bus.req       = 4'b0100;
        bus.out_ready = 1'b0;
        set_din(2, 8'hE7);
        step();
        expect_out("rst.pre", 4'b0100, 2'd2, 1'b1, 8'hE7);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst.async", 4'b0000, 2'd0, 1'b0, 8'h00);
        bus.req       = 4'b0000;
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        step();
        expect_out("rst.idle", 4'b0000, 2'd0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
